// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small power-of-two FIFO.
// Frame: start, DATA_BITS LSB first, optional parity, 1 or 2 stop bits; baud divisor latched per frame.
module uart_tx_fifo #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [DIV_W-1:0]                divisor,
    input  logic                            wr_en,
    input  logic [DATA_BITS-1:0]            wr_data,
    output logic                            full,
    output logic                            empty,
    output logic [$clog2(FIFO_DEPTH):0]     count,
    output logic                            busy,
    output logic                            overflow,
    input  logic                            clr_overflow,
    output logic                            tx
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BW = 4;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    state_e               state_q, state_d;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 full_q, full_d;
    logic                 empty_q, empty_d;
    logic                 ovf_q, ovf_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [DIV_W-1:0]     baud_q, baud_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic [BW-1:0]        bitcnt_q, bitcnt_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 push_c, pop_c, baud_end_c;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            div_q    <= '0;
            baud_q   <= '0;
            shreg_q  <= '0;
            par_q    <= 1'b0;
            bitcnt_q <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            div_q    <= div_d;
            baud_q   <= baud_d;
            shreg_q  <= shreg_d;
            par_q    <= par_d;
            bitcnt_q <= bitcnt_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by count_q
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Next-state, FIFO bookkeeping and serial output
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        div_d      = div_q;
        baud_d     = baud_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        bitcnt_d   = bitcnt_q;
        tx_d       = tx_q;
        pop_c      = 1'b0;
        push_c     = 1'b0;
        baud_end_c = (baud_q == '0);

        if (state_q != IDLE) begin
            baud_d = baud_end_c ? div_q : baud_q - 1'b1;
        end

        case (state_q)
            IDLE: begin
                pop_c = (count_q != '0);
            end
            START: begin
                if (baud_end_c) begin
                    state_d  = DATA;
                    bitcnt_d = '0;
                    tx_d     = shreg_q[0];
                end
            end
            DATA: begin
                if (baud_end_c) begin
                    if (bitcnt_q == BW'(DATA_BITS - 1)) begin
                        bitcnt_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bitcnt_d = bitcnt_q + 1'b1;
                        shreg_d  = shreg_q >> 1;
                        tx_d     = shreg_q[1];
                    end
                end
            end
            PARITY: begin
                if (baud_end_c) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (baud_end_c) begin
                    if (bitcnt_q == BW'(STOP_BITS - 1)) begin
                        if (count_q != '0) begin
                            pop_c = 1'b1;
                        end else begin
                            state_d = IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Loading a frame: head entry into the shifter, divisor latched for the whole frame
        if (pop_c) begin
            shreg_d  = mem_q[rd_ptr_q];
            par_d    = (^mem_q[rd_ptr_q]) ^ 1'(PARITY_ODD);
            div_d    = divisor;
            baud_d   = divisor;
            bitcnt_d = '0;
            state_d  = START;
            tx_d     = 1'b0;
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        push_c = wr_en && ((count_q != CW'(FIFO_DEPTH)) || pop_c);
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        case ({push_c, pop_c})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (wr_en && !push_c) begin
            ovf_d = 1'b1;
        end else if (clr_overflow) begin
            ovf_d = 1'b0;
        end

        full_d  = (count_d == CW'(FIFO_DEPTH));
        empty_d = (count_d == '0);
        busy_d  = (state_d != IDLE);
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign busy     = busy_q;
    assign overflow = ovf_q;
    assign tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench: four transmitter configurations share clock, reset and divisor.
// Instance 0 = 8N1, 1 = 8E1, 2 = 8O1, 3 = 8N2.
module tb_uart_tx_fifo;

    localparam int unsigned PE_T [4] = '{0, 1, 1, 0};
    localparam int unsigned PO_T [4] = '{0, 0, 1, 0};
    localparam int unsigned SB_T [4] = '{1, 1, 1, 2};

    logic        clk;
    logic        rst_n;
    logic [15:0] divisor;
    logic [3:0]  wr_en_v;
    logic [7:0]  wr_data;
    logic        clr_overflow;

    logic        full_w  [4];
    logic        empty_w [4];
    logic [2:0]  count_w [4];
    logic        busy_w  [4];
    logic        ovf_w   [4];
    logic        tx_w    [4];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        uart_tx_fifo #(
            .DATA_BITS (8),
            .FIFO_DEPTH(4),
            .DIV_W     (16),
            .PARITY_EN (PE_T[g]),
            .PARITY_ODD(PO_T[g]),
            .STOP_BITS (SB_T[g])
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .divisor     (divisor),
            .wr_en       (wr_en_v[g]),
            .wr_data     (wr_data),
            .full        (full_w[g]),
            .empty       (empty_w[g]),
            .count       (count_w[g]),
            .busy        (busy_w[g]),
            .overflow    (ovf_w[g]),
            .clr_overflow(clr_overflow),
            .tx          (tx_w[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Walks one frame clock by clock; clock 0 is the state after the pop edge.
    task automatic run_frame(input int idx, input logic [7:0] data, input logic par_bit,
                             input int pe, input int sb, input int div, input int offset);
        int   total;
        int   b;
        logic e;
        total = (1 + 8 + pe + sb) * (div + 1);
        for (int c = offset; c < total; c++) begin
            tick();
            b = c / (div + 1);
            if (b == 0)                e = 1'b0;
            else if (b <= 8)           e = data[b-1];
            else if (pe != 0 && b == 9) e = par_bit;
            else                       e = 1'b1;
            check($sformatf("tx[%0d] d=%0h clk%0d", idx, data, c), 32'(tx_w[idx]), 32'(e));
            check($sformatf("busy[%0d] d=%0h clk%0d", idx, data, c), 32'(busy_w[idx]), 32'd1);
        end
    endtask

    initial begin
        int lows;
        int busys;
        rst_n        = 1'b0;
        divisor      = 16'd3;
        wr_en_v      = 4'b0;
        wr_data      = 8'h00;
        clr_overflow = 1'b0;
        tick();
        tick();
        check("rst tx", 32'(tx_w[0]), 32'd1);
        check("rst busy", 32'(busy_w[0]), 32'd0);
        check("rst count", 32'(count_w[0]), 32'd0);
        check("rst empty", 32'(empty_w[0]), 32'd1);
        check("rst full", 32'(full_w[0]), 32'd0);
        check("rst ovf", 32'(ovf_w[0]), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: 8N1, divisor 3, 0x55
        wr_data = 8'h55; wr_en_v = 4'b0001;
        tick();
        wr_en_v = 4'b0;
        check("t1 count after push", 32'(count_w[0]), 32'd1);
        check("t1 tx idle after push", 32'(tx_w[0]), 32'd1);
        check("t1 busy idle after push", 32'(busy_w[0]), 32'd0);
        tick();
        check("t1 start tx", 32'(tx_w[0]), 32'd0);
        check("t1 empty after pop", 32'(empty_w[0]), 32'd1);
        check("t1 busy at start", 32'(busy_w[0]), 32'd1);
        run_frame(0, 8'h55, 1'b0, 0, 1, 3, 1);
        tick();
        check("t1 busy drop", 32'(busy_w[0]), 32'd0);
        check("t1 tx idle", 32'(tx_w[0]), 32'd1);

        // 2: even and odd parity, divisor 1, 0x07
        divisor = 16'd1;
        wr_data = 8'h07; wr_en_v = 4'b0010;
        tick();
        wr_en_v = 4'b0;
        run_frame(1, 8'h07, 1'b1, 1, 1, 1, 0);
        tick();
        check("t2 even busy drop", 32'(busy_w[1]), 32'd0);
        wr_en_v = 4'b0100;
        tick();
        wr_en_v = 4'b0;
        run_frame(2, 8'h07, 1'b0, 1, 1, 1, 0);
        tick();
        check("t2 odd busy drop", 32'(busy_w[2]), 32'd0);

        // 3: six pushes into depth-4 FIFO, divisor 1
        for (int i = 0; i < 6; i++) begin
            wr_data = 8'h11 + 8'(i); wr_en_v = 4'b0001;
            tick();
            if (i == 1) begin
                check("t3 count after edge1", 32'(count_w[0]), 32'd1);
                check("t3 tx start edge1", 32'(tx_w[0]), 32'd0);
            end
        end
        wr_en_v = 4'b0;
        check("t3 ovf", 32'(ovf_w[0]), 32'd1);
        check("t3 count", 32'(count_w[0]), 32'd4);
        check("t3 full", 32'(full_w[0]), 32'd1);
        run_frame(0, 8'h11, 1'b0, 0, 1, 1, 5);
        run_frame(0, 8'h12, 1'b0, 0, 1, 1, 0);
        run_frame(0, 8'h13, 1'b0, 0, 1, 1, 0);
        run_frame(0, 8'h14, 1'b0, 0, 1, 1, 0);
        run_frame(0, 8'h15, 1'b0, 0, 1, 1, 0);
        tick();
        check("t3 idle after 5 frames", 32'(busy_w[0]), 32'd0);
        check("t3 empty", 32'(empty_w[0]), 32'd1);
        check("t3 ovf sticky", 32'(ovf_w[0]), 32'd1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("t3 ovf cleared", 32'(ovf_w[0]), 32'd0);

        // 4: two stop bits, divisor 2, 0xA0
        divisor = 16'd2;
        wr_data = 8'hA0; wr_en_v = 4'b1000;
        tick();
        wr_en_v = 4'b0;
        run_frame(3, 8'hA0, 1'b0, 0, 2, 2, 0);
        tick();
        check("t4 busy drop", 32'(busy_w[3]), 32'd0);

        // 5: divisor changed mid-frame applies to the next frame only
        divisor = 16'd3;
        wr_data = 8'hC3; wr_en_v = 4'b0001;
        tick();
        wr_data = 8'h96;
        tick();
        wr_en_v = 4'b0;
        divisor = 16'd7;
        run_frame(0, 8'hC3, 1'b0, 0, 1, 3, 1);
        run_frame(0, 8'h96, 1'b0, 0, 1, 7, 0);
        tick();
        check("t5 busy drop", 32'(busy_w[0]), 32'd0);

        // 6: reset during DATA with two entries queued
        divisor = 16'd3;
        wr_en_v = 4'b0001;
        wr_data = 8'h3C; tick();
        wr_data = 8'h01; tick();
        wr_data = 8'h02; tick();
        wr_en_v = 4'b0;
        check("t6 queued", 32'(count_w[0]), 32'd2);
        for (int i = 0; i < 6; i++) tick();
        check("t6 data bit0", 32'(tx_w[0]), 32'd0);
        check("t6 busy in data", 32'(busy_w[0]), 32'd1);
        rst_n = 1'b0;
        tick();
        check("t6 rst tx", 32'(tx_w[0]), 32'd1);
        check("t6 rst busy", 32'(busy_w[0]), 32'd0);
        check("t6 rst count", 32'(count_w[0]), 32'd0);
        check("t6 rst empty", 32'(empty_w[0]), 32'd1);
        rst_n = 1'b1;
        lows  = 0;
        busys = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (tx_w[0] !== 1'b1) lows++;
            if (busy_w[0] !== 1'b0) busys++;
        end
        check("t6 no frames tx", 32'(lows), 32'd0);
        check("t6 no frames busy", 32'(busys), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an internal transmit FIFO. It drives the tt_um_cpu uo_out[4] serial pin, which is currently tied to idle. The CPU or a peripheral bus pushes bytes and the block serialises them at a runtime-programmable baud rate. Frame format is configurable: data bits, optional parity, and 1 or 2 stop bits.

Parameters:
- DATA_BITS, 8, data bits per frame (5..8), sent LSB first.
- FIFO_DEPTH, 4, FIFO entries; power of two, 2..16.
- DIV_W, 16, width of the baud divisor.
- PARITY_EN, 0, 1 = parity bit inserted after the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0).
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- divisor  in  DIV_W  cycles per bit minus 1; each bit lasts divisor+1 clocks.
- wr_en  in  1  push request.
- wr_data  in  DATA_BITS  byte to push.
- full  out  1  FIFO holds FIFO_DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- busy  out  1  FSM not in IDLE.
- overflow  out  1  sticky; a push was dropped.
- clr_overflow  in  1  clears overflow.
- tx  out  1  serial line, registered, idle high.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - tx=1, busy=0, count=0, empty=1, full=0, overflow=0.
  - FSM goes to IDLE, pointers go to 0, baud counter goes to 0.
  - Reset mid-frame aborts the frame immediately; tx returns to 1 on that edge.
- FIFO:
  - Push is accepted when wr_en=1 and (count<FIFO_DEPTH, or a pop occurs on the same edge).
  - A push to a full FIFO with no same-edge pop is dropped and sets overflow.
  - clr_overflow clears overflow. If a clear and a new drop occur on the same edge, the drop wins (overflow=1).
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when empty=0, pop the head entry into the shift register, latch divisor into the internal div_q, and go to START. tx=0 from that edge.
    - Latency: a push accepted at edge N into an empty FIFO while IDLE gives tx=0 after edge N+1.
  - Bit timing: a down-counter loads div_q at each bit start. The bit ends when the counter is 0, so each bit holds for exactly div_q+1 clocks. Changing divisor mid-frame has no effect until the next frame.
  - START: one bit time at tx=0, then DATA.
  - DATA: DATA_BITS bit times, shift register LSB first. Then go to PARITY if PARITY_EN, else STOP.
  - PARITY: one bit time. tx = XOR of the data bits, XOR PARITY_ODD.
  - STOP: STOP_BITS bit times at tx=1.
  - End of STOP:
    - If empty=0, pop and go directly to START on that edge (back-to-back frames, no idle gap).
    - Otherwise go to IDLE.
- Frame length in clocks: (div_q+1) × (1 + DATA_BITS + PARITY_EN + STOP_BITS).
- busy=1 in every state except IDLE.
- divisor=0 is legal: 1 clock per bit.

Test Plan:
1. 8N1, divisor=3; push 0x55 at edge 0.
   - Required: tx=0 over clocks 1–4, then data bits 1,0,1,0,1,0,1,0 at 4 clocks each, then stop=1 for 4 clocks.
   - busy is high for exactly 40 clocks; empty=1 after edge 1.
2. PARITY_EN=1, PARITY_ODD=0, divisor=1; push 0x07.
   - Required: parity bit = 1.
   - With PARITY_ODD=1, parity bit = 0; frame is 22 clocks.
3. FIFO_DEPTH=4, FSM idle; push 0x11..0x16 on six consecutive edges.
   - Required: 0x11 is popped at edge 1 and 0x16 is dropped.
   - overflow=1, count=4, full=1.
   - Frames are emitted back-to-back in order 0x11..0x15, with no idle clocks between stop and start.
   - clr_overflow pulse → overflow=0.
4. STOP_BITS=2, divisor=2; push 0xA0.
   - Required: the final 6 clocks are tx=1 before busy drops.
   - Total frame = 33 clocks.
5. Change divisor from 3 to 7 mid-frame.
   - Required: the current frame keeps 4-clock bits; the next frame uses 8-clock bits.
6. Assert rst_n=0 during DATA of 0x3C with 2 further entries queued.
   - Required: the next edge gives tx=1, busy=0, count=0, empty=1.
   - No further frames are emitted after reset is released.
